// File: rtl/memory_arbiter_if.sv
// Bus bundle for memory_arbiter: fetch port, data port and the shared memory port.
// The arbiter uses the slave modport; the requesters and the memory use master.
interface memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_width;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_re;
    logic              mem_we;
    logic [1:0]        mem_width;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  d_req, d_we, d_width, d_addr, d_wdata,
        output d_ack, d_rdata, d_err,
        output mem_re, mem_we, mem_width, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output d_req, d_we, d_width, d_addr, d_wdata,
        input  d_ack, d_rdata, d_err,
        input  mem_re, mem_we, mem_width, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (fetch / data) arbiter onto a single memory port with fixed read latency.
// Data normally wins; fetch is forced through after losing two arbitrations in a row.
module memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    memory_arbiter_if.slave      bus,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

    state_t            state;
    state_t            state_nxt;

    logic              grant_fetch;
    logic              lat_we;
    logic [1:0]        lat_width;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_err;
    logic [3:0]        wait_cnt;
    logic [1:0]        loss_cnt;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              any_req;
    logic              fetch_win;
    logic              req_err;

    function automatic logic data_bad(input logic [1:0] width, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (width)
            2'd1:    bad = lo[0];
            2'd2:    bad = (lo != 2'd0);
            2'd3:    bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Fetch only beats a concurrent data request once it has been starved twice.
    always_comb begin
        any_req   = bus.if_req | bus.d_req;
        fetch_win = bus.if_req & (~bus.d_req | (loss_cnt >= 2'd2));
        if (fetch_win) begin
            req_err = (bus.if_addr[1:0] != 2'd0);
        end else begin
            req_err = data_bad(bus.d_width, bus.d_addr[1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = req_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = lat_we ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latching, loss tracking, latency counting and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_fetch <= 1'b0;
            lat_we      <= 1'b0;
            lat_width   <= 2'd0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_err     <= 1'b0;
            wait_cnt    <= 4'd0;
            loss_cnt    <= 2'd0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_fetch <= fetch_win;
                        lat_err     <= req_err;
                        if (fetch_win) begin
                            lat_we    <= 1'b0;
                            lat_width <= 2'd2;
                            lat_addr  <= bus.if_addr;
                            lat_wdata <= '0;
                            loss_cnt  <= 2'd0;
                        end else begin
                            lat_we    <= bus.d_we;
                            lat_width <= bus.d_width;
                            lat_addr  <= bus.d_addr;
                            lat_wdata <= bus.d_wdata;
                            if (bus.if_req) begin
                                loss_cnt <= loss_cnt + 2'd1;
                            end
                        end
                        // An error completion reports zero read data on the winning port.
                        if (req_err) begin
                            if (fetch_win) begin
                                if_rdata_q <= '0;
                            end else begin
                                d_rdata_q <= '0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (!lat_we) begin
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        if (grant_fetch) begin
                            if_rdata_q <= bus.mem_rdata;
                        end else begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_re    = (state == ISSUE) & ~lat_we;
        bus.mem_we    = (state == ISSUE) &  lat_we;
        bus.mem_width = lat_width;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;

        bus.if_ack    = (state == RESP) &  grant_fetch;
        bus.d_ack     = (state == RESP) & ~grant_fetch;
        bus.if_err    = (state == RESP) &  grant_fetch & lat_err;
        bus.d_err     = (state == RESP) & ~grant_fetch & lat_err;
        bus.if_rdata  = if_rdata_q;
        bus.d_rdata   = d_rdata_q;

        busy          = (state != IDLE);
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: table vectors, random transactions against a
// rule-based model, contention ordering, reset mid-wait and maximum read latency.
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LAT1 = 1;
    localparam logic [31:0] BAD = 32'h0BAD_F00D;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic busy1, busy4, busy15;

    memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();
    memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus15 ();

    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1),  .busy(busy1));
    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4),  .busy(busy4));
    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(15)) dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15), .busy(busy15));

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem_array [0:255];
    logic [31:0] pipe1  [0:0];
    logic [31:0] pipe4  [0:3];
    logic [31:0] pipe15 [0:14];

    logic [31:0] exp_if_rd;
    logic [31:0] exp_d_rd;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_array[a[9:2]];
    endfunction

    // Memory delivers data exactly N cycles after the cycle in which mem_re was high.
    always @(posedge clk) begin
        pipe1[0] <= bus1.mem_re ? mem_word(bus1.mem_addr) : BAD;
        pipe4[0] <= bus4.mem_re ? mem_word(bus4.mem_addr) : BAD;
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
        pipe15[0] <= bus15.mem_re ? mem_word(bus15.mem_addr) : BAD;
        for (int i = 1; i < 15; i++) pipe15[i] <= pipe15[i-1];
    end

    assign bus1.mem_rdata  = pipe1[0];
    assign bus4.mem_rdata  = pipe4[3];
    assign bus15.mem_rdata = pipe15[14];

    function automatic logic model_err(input logic is_fetch, input logic [1:0] width, input logic [31:0] addr);
        if (is_fetch) return (addr % 4) != 0;
        if (width == 2'd3) return 1'b1;
        if (width == 2'd1) return (addr % 2) != 0;
        if (width == 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic int model_ack(input logic is_fetch, input logic we, input logic err);
        if (err) return 1;
        if (!is_fetch && we) return 2;
        return LAT1 + 2;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Drives one request on dut1 from cycle 0 and observes strobes and the ack.
    task automatic applyStimulus(
        input  logic        is_fetch,
        input  logic        we,
        input  logic [1:0]  width,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        output int          ack_cyc,
        output logic        err,
        output logic [31:0] rdata,
        output int          strobe_cnt,
        output int          strobe_cyc,
        output logic        strobe_we,
        output logic [31:0] s_addr,
        output logic [1:0]  s_width,
        output logic [31:0] s_wdata,
        output logic        extra_ack,
        output logic        overlap
    );
        ack_cyc = -1; err = 1'b0; rdata = '0; strobe_cnt = 0; strobe_cyc = -1;
        strobe_we = 1'b0; s_addr = '0; s_width = '0; s_wdata = '0;
        extra_ack = 1'b0; overlap = 1'b0;
        if (is_fetch) begin
            bus1.if_req = 1'b1; bus1.if_addr = addr;
        end else begin
            bus1.d_req = 1'b1; bus1.d_we = we; bus1.d_width = width;
            bus1.d_addr = addr; bus1.d_wdata = wdata;
        end
        for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (bus1.mem_re && bus1.mem_we) overlap = 1'b1;
            if (bus1.mem_re || bus1.mem_we) begin
                if (strobe_cnt == 0) begin
                    strobe_cyc = c; strobe_we = bus1.mem_we; s_addr = bus1.mem_addr;
                    s_width = bus1.mem_width; s_wdata = bus1.mem_wdata;
                end
                strobe_cnt++;
            end
            if (is_fetch ? bus1.d_ack : bus1.if_ack) extra_ack = 1'b1;
            if (is_fetch ? bus1.if_ack : bus1.d_ack) begin
                ack_cyc = c;
                err   = is_fetch ? bus1.if_err : bus1.d_err;
                rdata = is_fetch ? bus1.if_rdata : bus1.d_rdata;
            end
        end
        bus1.if_req = 1'b0;
        bus1.d_req  = 1'b0;
        @(negedge clk);
        if (bus1.mem_re || bus1.mem_we) strobe_cnt++;
        if (bus1.if_ack || bus1.d_ack) extra_ack = 1'b1;
    endtask

    task automatic checkTxn(input string tag, input logic is_fetch, input logic we, input logic [1:0] width,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic exp_err, input int exp_ack);
        int ack_cyc, strobe_cnt, strobe_cyc;
        logic err, strobe_we, extra_ack, overlap;
        logic [31:0] rdata, s_addr, s_wdata, exp_rd;
        logic [1:0] s_width;
        logic store;
        store = !is_fetch && we;
        applyStimulus(is_fetch, we, width, addr, wdata, ack_cyc, err, rdata, strobe_cnt, strobe_cyc,
                      strobe_we, s_addr, s_width, s_wdata, extra_ack, overlap);
        if (exp_err) exp_rd = '0;
        else if (store) exp_rd = exp_d_rd;
        else exp_rd = mem_word(addr);
        if (is_fetch) exp_if_rd = exp_rd; else exp_d_rd = exp_rd;

        checkOutput({tag, " ack_cycle"}, 32'(ack_cyc), 32'(exp_ack));
        checkOutput({tag, " err"}, 32'(err), 32'(exp_err));
        checkOutput({tag, " rdata"}, rdata, exp_rd);
        checkOutput({tag, " strobe_count"}, 32'(strobe_cnt), exp_err ? 32'd0 : 32'd1);
        checkOutput({tag, " other_ack"}, 32'(extra_ack), 32'd0);
        checkOutput({tag, " re_we_overlap"}, 32'(overlap), 32'd0);
        if (!exp_err) begin
            checkOutput({tag, " strobe_cycle"}, 32'(strobe_cyc), 32'd1);
            checkOutput({tag, " strobe_is_write"}, 32'(strobe_we), 32'(store));
            checkOutput({tag, " mem_addr"}, s_addr, addr);
            checkOutput({tag, " mem_width"}, 32'(s_width), is_fetch ? 32'd2 : 32'(width));
            if (store) checkOutput({tag, " mem_wdata"}, s_wdata, wdata);
        end
    endtask

    typedef struct {
        logic        is_fetch;
        logic        we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_ack;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ack_cyc, busy_cnt, ack_cnt, grants;
        logic busy_after;
        byte order [6];
        byte exp_order [6];
        logic [31:0] last_rd;

        for (int i = 0; i < 256; i++) mem_array[i] = {i[7:0], 8'h5A, ~i[7:0], 8'hC3};
        mem_array[4] = 32'hDEADBEEF;

        bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_width = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
        bus4.if_req = 0; bus4.if_addr = '0; bus4.d_req = 0; bus4.d_we = 0; bus4.d_width = '0; bus4.d_addr = '0; bus4.d_wdata = '0;
        bus15.if_req = 0; bus15.if_addr = '0; bus15.d_req = 0; bus15.d_we = 0; bus15.d_width = '0; bus15.d_addr = '0; bus15.d_wdata = '0;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset busy", 32'(busy1), 32'd0);
        checkOutput("reset mem_re", 32'(bus1.mem_re), 32'd0);
        checkOutput("reset if_ack", 32'(bus1.if_ack), 32'd0);
        checkOutput("reset d_rdata", bus1.d_rdata, 32'd0);
        exp_if_rd = '0;
        exp_d_rd = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{1'b1, 1'b0, 2'd0, 32'h10, 32'h0,  1'b0, 3};
        vecs[1] = '{1'b0, 1'b1, 2'd0, 32'h3,  32'hAB, 1'b0, 2};
        vecs[2] = '{1'b0, 1'b0, 2'd1, 32'h5,  32'h0,  1'b1, 1};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 32'h2,  32'h0,  1'b1, 1};
        vecs[4] = '{1'b0, 1'b0, 2'd2, 32'h8,  32'h0,  1'b0, 3};
        vecs[5] = '{1'b0, 1'b0, 2'd3, 32'h0,  32'h0,  1'b1, 1};
        vecs[6] = '{1'b0, 1'b1, 2'd1, 32'h6,  32'h1234, 1'b0, 2};
        vecs[7] = '{1'b0, 1'b1, 2'd2, 32'h6,  32'h55, 1'b1, 1};
        vecs[8] = '{1'b0, 1'b0, 2'd0, 32'h7,  32'h0,  1'b0, 3};
        vecs[9] = '{1'b1, 1'b0, 2'd0, 32'h1,  32'h0,  1'b1, 1};
        for (int i = 0; i < 10; i++) begin
            checkTxn($sformatf("vec%0d", i), vecs[i].is_fetch, vecs[i].we, vecs[i].width,
                     vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_ack);
        end

        // Both ports held high: data, data, then the starved fetch.
        exp_order[0] = "D"; exp_order[1] = "D"; exp_order[2] = "I";
        exp_order[3] = "D"; exp_order[4] = "D"; exp_order[5] = "I";
        for (int i = 0; i < 6; i++) order[i] = "-";
        grants = 0;
        bus1.if_addr = 32'h20; bus1.d_addr = 32'h40; bus1.d_we = 1'b0; bus1.d_width = 2'd2;
        bus1.if_req = 1'b1; bus1.d_req = 1'b1;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            @(negedge clk);
            if (bus1.if_ack || bus1.d_ack) begin
                order[grants] = (bus1.if_ack && bus1.d_ack) ? "X" : (bus1.d_ack ? "D" : "I");
                grants++;
            end
        end
        bus1.if_req = 1'b0; bus1.d_req = 1'b0;
        @(negedge clk);
        checkOutput("contention grants", 32'(grants), 32'd6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("contention grant%0d", i), 32'(order[i]), 32'(exp_order[i]));
        exp_if_rd = mem_word(32'h20);
        exp_d_rd = mem_word(32'h40);

        for (int i = 0; i < 40; i++) begin
            logic f, w, e;
            logic [1:0] wd;
            logic [31:0] a, d;
            f = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            wd = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 1023));
            d = $urandom;
            e = model_err(f, wd, a);
            checkTxn($sformatf("rand%0d", i), f, w, wd, a, d, e, model_ack(f, w, e));
        end

        // RD_LAT=4: complete one fetch, then reset in the second WAIT cycle of the next.
        bus4.if_addr = 32'h30; bus4.if_req = 1'b1;
        ack_cyc = -1;
        for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (bus4.if_ack) begin
                ack_cyc = c;
                last_rd = bus4.if_rdata;
            end
        end
        bus4.if_req = 1'b0;
        checkOutput("lat4 ack_cycle", 32'(ack_cyc), 32'd6);
        checkOutput("lat4 rdata", last_rd, mem_word(32'h30));
        @(negedge clk);
        bus4.if_addr = 32'h34; bus4.if_req = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("lat4 busy before reset", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("lat4 reset busy", 32'(busy4), 32'd0);
        checkOutput("lat4 reset mem_addr", bus4.mem_addr, 32'd0);
        checkOutput("lat4 reset if_rdata", bus4.if_rdata, 32'd0);
        checkOutput("lat4 reset if_ack", 32'(bus4.if_ack), 32'd0);
        bus4.if_req = 1'b0;
        ack_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus4.if_ack || bus4.d_ack || bus4.mem_re) ack_cnt++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus4.if_ack || bus4.d_ack || bus4.mem_re) ack_cnt++;
        end
        checkOutput("lat4 abandoned activity", 32'(ack_cnt), 32'd0);
        bus4.if_addr = 32'h38; bus4.if_req = 1'b1;
        ack_cyc = -1;
        for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (bus4.if_ack) begin
                ack_cyc = c;
                last_rd = bus4.if_rdata;
            end
        end
        bus4.if_req = 1'b0;
        checkOutput("lat4 post-reset ack_cycle", 32'(ack_cyc), 32'd6);
        checkOutput("lat4 post-reset rdata", last_rd, mem_word(32'h38));

        // RD_LAT=15 load.
        @(negedge clk);
        bus15.d_addr = 32'h44; bus15.d_width = 2'd2; bus15.d_we = 1'b0; bus15.d_req = 1'b1;
        ack_cyc = -1; busy_cnt = 0; busy_after = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c <= 17 && busy15) busy_cnt++;
            if (c == 18) busy_after = busy15;
            if (bus15.d_ack && ack_cyc < 0) begin
                ack_cyc = c;
                last_rd = bus15.d_rdata;
                bus15.d_req = 1'b0;
            end
        end
        bus15.d_req = 1'b0;
        checkOutput("lat15 ack_cycle", 32'(ack_cyc), 32'd17);
        checkOutput("lat15 busy cycles", 32'(busy_cnt), 32'd17);
        checkOutput("lat15 busy after ack", 32'(busy_after), 32'd0);
        checkOutput("lat15 rdata", last_rd, mem_word(32'h44));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
